ecp8_alu_writeback: RTL and testbench
=====================================

# ecp8_alu_writeback

Writeback stage directly downstream of the ECP8 ALU. It captures the ALU's low result byte, optional high result byte, enable and carry in one handshake. It then drives one or two register-file writes: low byte to `dest`, high byte to `dest+1`. It also maintains the architectural flags register consumed by the branch/condition logic.

## Interface
Parameters:
- `REG_ADDR_W`, default 3: register-file address width (8 registers).

Ports:
- `clk`, input, 1: single clock; all state on rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `in_valid`, input, 1: ALU result and `dest` valid this cycle.
- `in_ready`, output, 1: stage can accept a result this cycle.
- `dest`, input, `REG_ADDR_W`: destination register index.
- `alu_c`, input, 8: ALU low/primary result (`C`).
- `alu_d`, input, 8: ALU high result (`D`, mul high / mod).
- `alu_d_en`, input, 1: `alu_d` is valid; a second write is required.
- `alu_cf`, input, 1: ALU carry flag.
- `flag_we`, input, 1: the accepted result updates the flags.
- `rf_we`, output, 1: register-file write strobe.
- `rf_waddr`, output, `REG_ADDR_W`: register-file write address.
- `rf_wdata`, output, 8: register-file write data.
- `flags`, output, 3: bit 0 = C, bit 1 = Z, bit 2 = N.
- `busy`, output, 1: a write is pending or in progress (state ≠ IDLE).

## Operation
- The accept condition is `in_valid && in_ready`. It latches `dest`, `alu_c`, `alu_d`, `alu_d_en` into hold registers.
- `in_ready = !(state == WR_LO && hold_d_en)`. This stalls upstream only while a high-byte write is still owed.
- **IDLE**
  - `rf_we = 0`.
  - On accept, go to WR_LO.
- **WR_LO**
  - Drives `rf_we = 1`, `rf_waddr = hold_dest`, `rf_wdata = hold_c`.
  - If `hold_d_en`, go to WR_HI.
  - Otherwise, on accept, stay in WR_LO with the new data. With no accept, go to IDLE.
- **WR_HI**
  - Drives `rf_we = 1`, `rf_waddr = hold_dest + 1`, `rf_wdata = hold_d`.
  - The address wraps modulo 2^`REG_ADDR_W` (e.g. dest 7 writes hi to 0).
  - On accept, go to WR_LO; otherwise go to IDLE.
- **Flags**
  - Updated at the accept edge only, and only if `flag_we`.
  - C = `alu_cf`.
  - Z = (`alu_c == 0`) && (!`alu_d_en` || `alu_d == 0`).
  - N = `alu_d_en` ? `alu_d[7]` : `alu_c[7]`.
  - With `flag_we = 0`, flags hold their value.
- `rf_we`, `rf_waddr`, `rf_wdata` are registered outputs. No combinational path runs from any input to any output except `in_ready`.
- `dest` equal to the register read next cycle is not forwarded here. Hazards belong to the issue logic.

## Timing
- Reset (`rst = 0`, async):
  - state = IDLE
  - `rf_we = 0`, `rf_waddr = 0`, `rf_wdata = 0`
  - `flags = 3'b000`, `busy = 0`
  - hold registers = 0
  - `in_ready = 1` from the first cycle after release.
- Reset mid-operation aborts immediately. A pending WR_HI write is dropped, and `rf_we` falls asynchronously.
- Latency: accept at edge k → low write visible during cycle k+1 → high write (if any) during cycle k+2.
- Flags are visible from cycle k+1.
- Throughput: one single-byte result per cycle; a double-byte result occupies 2 cycles.
- If `in_valid` is asserted while `in_ready = 0`, the inputs are ignored. Upstream must hold them until accepted.

## Configuration
- Macro: `ECP8_WB_ZN_FLAGS_EN`.
- Defined: full C/Z/N flag generation as above.
- Undefined:
  - Only C is stored.
  - `flags[2:1]` are tied to 0.
  - The Z/N logic and registers are not compiled in.

## Structure
- Shared package `ecp8_pkg` holds:
  - the state enum (IDLE, WR_LO, WR_HI);
  - the flag bit indices (`FLAG_C = 0`, `FLAG_Z = 1`, `FLAG_N = 2`);
  - the flags width constant.
- One sub-module: `ecp8_flag_gen`. It is combinational and produces next-flag values from `alu_c`, `alu_d`, `alu_d_en` and `alu_cf`. It is instantiated only under `ECP8_WB_ZN_FLAGS_EN` (C passthrough otherwise).

## Test plan
- **Single-byte write:** accept dest=2, c=0x5A, d_en=0, cf=1, flag_we=1.
  - Next cycle: `rf_we = 1`, addr 2, data 0x5A.
  - `flags = 3'b001`.
  - Cycle after that: IDLE, `rf_we = 0`.
- **Double-byte write with wrap:** accept dest=7, c=0x00, d=0x80, d_en=1.
  - Expect addr 7 / data 0x00, then addr 0 / data 0x80.
  - `in_ready = 0` during the low write.
  - Z = 0, N = 1.
- **Back-to-back single-byte:** 4 consecutive accepts on dests 0..3.
  - Expect 4 consecutive `rf_we` cycles, in order.
  - `in_ready` stays 1 throughout.
- **Zero result, flags held:**
  - Accept c=0, d_en=0, flag_we=1 → Z = 1.
  - Next accept c=0xFF, flag_we=0 → flags unchanged at Z = 1.
- **Reset during WR_HI:** assert `rst = 0` mid-cycle.
  - `rf_we` drops immediately.
  - After release: no high write, `flags = 0`, `in_ready = 1`.
- **Macro undefined:** a result with c=0 and flag_we=1 yields `flags = {0, 0, cf}`.

Source files
------------

// File: rtl/ecp8_pkg.sv
// rtl/ecp8_pkg.sv - shared writeback state encoding and flag bit layout
package ecp8_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } wb_state_t;

  localparam int FLAGS_W = 3;
  localparam int FLAG_C  = 0;
  localparam int FLAG_Z  = 1;
  localparam int FLAG_N  = 2;

endpackage

// File: rtl/ecp8_alu_writeback_if.sv
// rtl/ecp8_alu_writeback_if.sv - ALU result handshake and register-file write port bundle
interface ecp8_alu_writeback_if #(
  parameter int REG_ADDR_W = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] dest;
  logic [7:0]            alu_c;
  logic [7:0]            alu_d;
  logic                  alu_d_en;
  logic                  alu_cf;
  logic                  flag_we;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [7:0]            rf_wdata;

  modport master (
    output in_valid, dest, alu_c, alu_d, alu_d_en, alu_cf, flag_we,
    input  in_ready, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  in_valid, dest, alu_c, alu_d, alu_d_en, alu_cf, flag_we,
    output in_ready, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/ecp8_flag_gen.sv
// rtl/ecp8_flag_gen.sv - combinational next C/Z/N flags for an ALU result
module ecp8_flag_gen
  import ecp8_pkg::*;
(
  input  logic [7:0]         alu_c,
  input  logic [7:0]         alu_d,
  input  logic               alu_d_en,
  input  logic               alu_cf,
  output logic [FLAGS_W-1:0] next_flags
);

  // Z and N describe the whole result, so the high byte joins in when present
  always_comb begin
    next_flags         = '0;
    next_flags[FLAG_C] = alu_cf;
    next_flags[FLAG_Z] = (alu_c == 8'h00) && (!alu_d_en || (alu_d == 8'h00));
    next_flags[FLAG_N] = alu_d_en ? alu_d[7] : alu_c[7];
  end

endmodule

// File: rtl/ecp8_alu_writeback.sv
// rtl/ecp8_alu_writeback.sv - ALU writeback: one/two register writes plus flags (ECP8_WB_ZN_FLAGS_EN adds Z/N)
module ecp8_alu_writeback
  import ecp8_pkg::*;
#(
  parameter int REG_ADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  ecp8_alu_writeback_if.slave bus,
  output logic [FLAGS_W-1:0] flags,
  output logic               busy
);

  wb_state_t             state, state_nxt;
  logic [REG_ADDR_W-1:0] hold_dest;
  logic [7:0]            hold_c;
  logic [7:0]            hold_d;
  logic                  hold_d_en;
  logic                  accept;
  logic                  we_nxt;
  logic [REG_ADDR_W-1:0] waddr_nxt;
  logic [7:0]            wdata_nxt;

  // Upstream only stalls while the high byte of the current result is still owed
  assign bus.in_ready = !(state == WR_LO && hold_d_en);
  assign accept       = bus.in_valid && bus.in_ready;
  assign busy         = (state != IDLE);

  always_comb begin
    state_nxt = state;
    we_nxt    = 1'b0;
    waddr_nxt = bus.rf_waddr;
    wdata_nxt = bus.rf_wdata;
    case (state)
      IDLE:    state_nxt = accept ? WR_LO : IDLE;
      WR_LO: begin
        if (hold_d_en)   state_nxt = WR_HI;
        else if (accept) state_nxt = WR_LO;
        else             state_nxt = IDLE;
      end
      WR_HI:   state_nxt = accept ? WR_LO : IDLE;
      default: state_nxt = IDLE;
    endcase
    // Write port is registered, so stage next cycle's write from the next state
    if (state_nxt == WR_HI) begin
      we_nxt    = 1'b1;
      waddr_nxt = hold_dest + 1'b1;
      wdata_nxt = hold_d;
    end else if (accept) begin
      we_nxt    = 1'b1;
      waddr_nxt = bus.dest;
      wdata_nxt = bus.alu_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      hold_dest    <= '0;
      hold_c       <= 8'h00;
      hold_d       <= 8'h00;
      hold_d_en    <= 1'b0;
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= 8'h00;
    end else begin
      state        <= state_nxt;
      bus.rf_we    <= we_nxt;
      bus.rf_waddr <= waddr_nxt;
      bus.rf_wdata <= wdata_nxt;
      if (accept) begin
        hold_dest <= bus.dest;
        hold_c    <= bus.alu_c;
        hold_d    <= bus.alu_d;
        hold_d_en <= bus.alu_d_en;
      end
    end
  end

`ifdef ECP8_WB_ZN_FLAGS_EN
  logic [FLAGS_W-1:0] flags_nxt;
  logic [FLAGS_W-1:0] flags_q;

  ecp8_flag_gen u_flag_gen (
    .alu_c      (bus.alu_c),
    .alu_d      (bus.alu_d),
    .alu_d_en   (bus.alu_d_en),
    .alu_cf     (bus.alu_cf),
    .next_flags (flags_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      flags_q <= '0;
    else if (accept && bus.flag_we) flags_q <= flags_nxt;
  end

  assign flags = flags_q;
`else
  logic carry_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      carry_q <= 1'b0;
    else if (accept && bus.flag_we) carry_q <= bus.alu_cf;
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_C] = carry_q;
  end
`endif

endmodule

// File: tb/tb_ecp8_alu_writeback.sv
// tb/tb_ecp8_alu_writeback.sv - scoreboard bench for ecp8_alu_writeback with a result-level reference model
module tb_ecp8_alu_writeback;

  typedef struct {
    logic [2:0] dest;
    logic [7:0] c;
    logic [7:0] d;
    logic       d_en;
    logic       cf;
    logic       fwe;
    int         gap;
  } item_t;

  typedef struct {
    int         cyc;
    logic [2:0] addr;
    logic [7:0] data;
    logic [2:0] flg;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] flags;
  logic       busy;

  int   cyc = 0;
  int   hi_lo_cyc = -1;
  int   total = 0;
  int   passed = 0;
  logic [2:0] model_flags = 3'b000;
  exp_t q[$];
  exp_t mon_e;
  bit   mon_we;

  ecp8_alu_writeback_if #(.REG_ADDR_W(3)) bus ();

  ecp8_alu_writeback #(.REG_ADDR_W(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .flags (flags),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Flags the architecture defines for a whole result, from plain arithmetic
  function automatic logic [2:0] result_flags(input item_t it);
    int value;
    logic z, n;
    value = it.d_en ? (int'(it.d) * 256 + int'(it.c)) : int'(it.c);
    z = (value == 0);
    n = it.d_en ? (it.d >= 8'd128) : (it.c >= 8'd128);
`ifdef ECP8_WB_ZN_FLAGS_EN
    return {n, z, it.cf};
`else
    return {1'b0 & n, 1'b0 & z, it.cf};
`endif
  endfunction

  task automatic check_ready();
    chk("in_ready", int'(bus.in_ready), (cyc == hi_lo_cyc) ? 0 : 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      check_ready();
    end
  endtask

  task automatic send(input item_t it);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dest     = it.dest;
    bus.alu_c    = it.c;
    bus.alu_d    = it.d;
    bus.alu_d_en = it.d_en;
    bus.alu_cf   = it.cf;
    bus.flag_we  = it.fwe;
    check_ready();
    while (!bus.in_ready && guard < 8) begin
      @(negedge clk);
      check_ready();
      guard++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    if (it.fwe) model_flags = result_flags(it);
    e.cyc  = cyc + 1;
    e.addr = it.dest;
    e.data = it.c;
    e.flg  = model_flags;
    q.push_back(e);
    if (it.d_en) begin
      e.cyc  = cyc + 2;
      e.addr = 3'((int'(it.dest) + 1) % 8);
      e.data = it.d;
      q.push_back(e);
      hi_lo_cyc = cyc + 1;
    end
    if (it.gap > 0) idle(it.gap);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon_we = (q.size() > 0) && (q[0].cyc == cyc);
      chk("rf_we", int'(bus.rf_we), int'(mon_we));
      chk("busy", int'(busy), int'(mon_we));
      if (mon_we) begin
        mon_e = q.pop_front();
        chk("rf_waddr", int'(bus.rf_waddr), int'(mon_e.addr));
        chk("rf_wdata", int'(bus.rf_wdata), int'(mon_e.data));
        chk("flags", int'(flags), int'(mon_e.flg));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (got running, expected done)");
    $fatal(1, "watchdog");
  end

  initial begin
    item_t it;
    bus.in_valid = 1'b0;
    bus.dest     = '0;
    bus.alu_c    = 8'h00;
    bus.alu_d    = 8'h00;
    bus.alu_d_en = 1'b0;
    bus.alu_cf   = 1'b0;
    bus.flag_we  = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_rf_we", int'(bus.rf_we), 0);
    chk("reset_rf_waddr", int'(bus.rf_waddr), 0);
    chk("reset_rf_wdata", int'(bus.rf_wdata), 0);
    chk("reset_flags", int'(flags), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b1;

    send('{dest:3'd2, c:8'h5A, d:8'h00, d_en:1'b0, cf:1'b1, fwe:1'b1, gap:2});
    send('{dest:3'd7, c:8'h00, d:8'h80, d_en:1'b1, cf:1'b0, fwe:1'b1, gap:3});
    for (int i = 0; i < 4; i++)
      send('{dest:3'(i), c:8'(8'h10 + i), d:8'h00, d_en:1'b0, cf:1'b0, fwe:1'b1, gap:(i == 3) ? 2 : 0});
    send('{dest:3'd4, c:8'h00, d:8'h00, d_en:1'b0, cf:1'b0, fwe:1'b1, gap:0});
    send('{dest:3'd5, c:8'hFF, d:8'h00, d_en:1'b0, cf:1'b1, fwe:1'b0, gap:2});
    send('{dest:3'd6, c:8'h00, d:8'h00, d_en:1'b1, cf:1'b1, fwe:1'b1, gap:3});

    // Abort a result while its high-byte write is in flight
    send('{dest:3'd3, c:8'h11, d:8'h22, d_en:1'b1, cf:1'b1, fwe:1'b1, gap:0});
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_ready();
    @(posedge clk);
    #2;
    q.delete();
    rst = 1'b0;
    #1;
    chk("abort_rf_we", int'(bus.rf_we), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_flags", int'(flags), 0);
    model_flags = 3'b000;
    hi_lo_cyc = -1;
    @(negedge clk);
    rst = 1'b1;
    idle(3);

    for (int i = 0; i < 300; i++) begin
      it.dest = 3'($urandom_range(0, 7));
      it.c    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      it.d    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      it.d_en = 1'($urandom_range(0, 1));
      it.cf   = 1'($urandom_range(0, 1));
      it.fwe  = ($urandom_range(0, 3) != 0);
      it.gap  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      send(it);
    end
    idle(5);
    chk("scoreboard_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
